// File: rtl/periph_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the peripheral demux/read mux.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface periph_bus_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m1_req;
  logic              m0_we;
  logic              m1_we;
  logic [7:0]        m0_addr;
  logic [7:0]        m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_ack;
  logic              m1_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m0_err;
  logic              m1_err;
  logic [2:0]        SEL;
  logic              WE_procesador;
  logic [4:0]        bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err,
           SEL, WE_procesador, bus_addr, bus_wdata, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err,
           SEL, WE_procesador, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and fixed-latency access sequencer for the peripheral bus.
// Optional feature: define UNMAPPED_ERR_EN to error-terminate accesses to SEL 1 and 7.
module periph_bus_arbiter #(
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  periph_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              we_q;
  logic              we_strobe_q;
  logic [2:0]        sel_q;
  logic [4:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              err0_q;
  logic              err1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              grant_d;
  logic              unmapped;

  // Lone requester wins outright; under contention the master not served last wins.
  always_comb begin
    grant_d = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      grant_d = ~last_grant_q;
    end
  end

`ifdef UNMAPPED_ERR_EN
  assign unmapped = (sel_q == 3'd1) || (sel_q == 3'd7);
`else
  assign unmapped = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      we_strobe_q  <= 1'b0;
      sel_q        <= 3'd0;
      addr_q       <= 5'd0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      we_strobe_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            gnt_q   <= grant_d;
            sel_q   <= grant_d ? bus.m1_addr[7:5] : bus.m0_addr[7:5];
            addr_q  <= grant_d ? bus.m1_addr[4:0] : bus.m0_addr[4:0];
            wdata_q <= grant_d ? bus.m1_wdata : bus.m0_wdata;
            we_q    <= grant_d ? bus.m1_we : bus.m0_we;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (unmapped) begin
            // Error completion: no strobe, rdata cleared so stale data is never mistaken for a read.
            if (gnt_q) begin
              ack1_q   <= 1'b1;
              err1_q   <= 1'b1;
              rdata1_q <= '0;
            end else begin
              ack0_q   <= 1'b1;
              err0_q   <= 1'b1;
              rdata0_q <= '0;
            end
            state_q <= DONE;
          end else begin
            cnt_q       <= WAIT_LD;
            we_strobe_q <= we_q;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (gnt_q) begin
              ack1_q <= 1'b1;
              if (!we_q) rdata1_q <= bus.bus_rdata;
            end else begin
              ack0_q <= 1'b1;
              if (!we_q) rdata0_q <= bus.bus_rdata;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack        = ack0_q;
  assign bus.m1_ack        = ack1_q;
  assign bus.m0_err        = err0_q;
  assign bus.m1_err        = err1_q;
  assign bus.m0_rdata      = rdata0_q;
  assign bus.m1_rdata      = rdata1_q;
  assign bus.SEL           = sel_q;
  assign bus.WE_procesador = we_strobe_q;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_wdata     = wdata_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed, table-driven bench for periph_bus_arbiter; prints one line per transaction.
// Expectations follow UNMAPPED_ERR_EN when the bench is built with that macro.
module tb_periph_bus_arbiter;

`ifdef UNMAPPED_ERR_EN
  localparam bit UNM = 1'b1;
`else
  localparam bit UNM = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  periph_bus_arbiter_if #(.DATA_W(32)) bif   ();
  periph_bus_arbiter_if #(.DATA_W(32)) bif0  ();
  periph_bus_arbiter_if #(.DATA_W(32)) bif15 ();

  periph_bus_arbiter #(.DATA_W(32), .WAIT_CYC(1))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
  periph_bus_arbiter #(.DATA_W(32), .WAIT_CYC(0))  u_dut0  (.clk(clk), .rst_n(rst_n), .bus(bif0.slave));
  periph_bus_arbiter #(.DATA_W(32), .WAIT_CYC(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bif15.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [7:0]  a0, a1;
    logic [31:0] wd0, wd1, brd;
    int          ack0_n, ack1_n;
    logic [31:0] rd0, rd1;
    logic        err0, err1;
    int          we_first, we_cnt;
    logic [2:0]  sel1;
    logic [4:0]  addr1;
    logic [31:0] wdc1;
    logic [2:0]  last_sel;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(
      input logic r0, r1, we0, we1, input logic [7:0] a0, a1,
      input logic [31:0] wd0, wd1, brd, input int ack0_n, ack1_n,
      input logic [31:0] rd0, rd1, input logic err0, err1,
      input int we_first, we_cnt, input logic [2:0] sel1, input logic [4:0] addr1,
      input logic [31:0] wdc1, input logic [2:0] last_sel);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.brd = brd; v.ack0_n = ack0_n; v.ack1_n = ack1_n;
    v.rd0 = rd0; v.rd1 = rd1; v.err0 = err0; v.err1 = err1;
    v.we_first = we_first; v.we_cnt = we_cnt; v.sel1 = sel1; v.addr1 = addr1;
    v.wdc1 = wdc1; v.last_sel = last_sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int n, got0, got1, wef, wec;
    n = 0; got0 = 0; got1 = 0; wef = 0; wec = 0;
    @(negedge clk);
    bif.m0_req = v.r0; bif.m1_req = v.r1; bif.m0_we = v.we0; bif.m1_we = v.we1;
    bif.m0_addr = v.a0; bif.m1_addr = v.a1; bif.m0_wdata = v.wd0; bif.m1_wdata = v.wd1;
    bif.bus_rdata = v.brd;
    while (((v.r0 && got0 == 0) || (v.r1 && got1 == 0)) && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk($sformatf("v%0d sel", idx), 32'(bif.SEL), 32'(v.sel1));
        chk($sformatf("v%0d bus_addr", idx), 32'(bif.bus_addr), 32'(v.addr1));
        chk($sformatf("v%0d bus_wdata", idx), bif.bus_wdata, v.wdc1);
        chk($sformatf("v%0d busy", idx), 32'(bif.busy), 32'd1);
      end
      if (bif.WE_procesador) begin
        wec++;
        if (wef == 0) wef = n;
      end
      if (bif.m0_ack && bif.m1_ack) chk($sformatf("v%0d dual_ack", idx), 32'd1, 32'd0);
      if (bif.m0_ack && got0 == 0) begin
        got0 = n;
        chk($sformatf("v%0d m0_err", idx), 32'(bif.m0_err), 32'(v.err0));
        chk($sformatf("v%0d m0_rdata", idx), bif.m0_rdata, v.rd0);
        bif.m0_req = 1'b0;
      end
      if (bif.m1_ack && got1 == 0) begin
        got1 = n;
        chk($sformatf("v%0d m1_err", idx), 32'(bif.m1_err), 32'(v.err1));
        chk($sformatf("v%0d m1_rdata", idx), bif.m1_rdata, v.rd1);
        bif.m1_req = 1'b0;
      end
    end
    bif.m0_req = 1'b0; bif.m1_req = 1'b0;
    chk($sformatf("v%0d m0_ack_cycle", idx), 32'(got0), 32'(v.ack0_n));
    chk($sformatf("v%0d m1_ack_cycle", idx), 32'(got1), 32'(v.ack1_n));
    chk($sformatf("v%0d we_first", idx), 32'(wef), 32'(v.we_first));
    chk($sformatf("v%0d we_cnt", idx), 32'(wec), 32'(v.we_cnt));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d idle_busy", idx), 32'(bif.busy), 32'd0);
    chk($sformatf("v%0d idle_sel_hold", idx), 32'(bif.SEL), 32'(v.last_sel));
    chk($sformatf("v%0d idle_we", idx), 32'(bif.WE_procesador), 32'd0);
    $display("txn v%0d: ack0@%0d ack1@%0d we@%0d x%0d m0_rdata=%h m1_rdata=%h",
             idx, got0, got1, wef, wec, bif.m0_rdata, bif.m1_rdata);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " SEL"}, 32'(bif.SEL), 32'd0);
    chk({tag, " WE"}, 32'(bif.WE_procesador), 32'd0);
    chk({tag, " bus_addr"}, 32'(bif.bus_addr), 32'd0);
    chk({tag, " bus_wdata"}, bif.bus_wdata, 32'd0);
    chk({tag, " acks"}, 32'({bif.m0_ack, bif.m1_ack}), 32'd0);
    chk({tag, " errs"}, 32'({bif.m0_err, bif.m1_err}), 32'd0);
    chk({tag, " m0_rdata"}, bif.m0_rdata, 32'd0);
    chk({tag, " m1_rdata"}, bif.m1_rdata, 32'd0);
    chk({tag, " busy"}, 32'(bif.busy), 32'd0);
  endtask

  initial begin
    int n, got0, got15, ack_seen;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    bif.m0_req = 0; bif.m1_req = 0; bif.m0_we = 0; bif.m1_we = 0;
    bif.m0_addr = 0; bif.m1_addr = 0; bif.m0_wdata = 0; bif.m1_wdata = 0; bif.bus_rdata = 0;
    bif0.m0_req = 0; bif0.m1_req = 0; bif0.m0_we = 0; bif0.m1_we = 0;
    bif0.m0_addr = 0; bif0.m1_addr = 0; bif0.m0_wdata = 0; bif0.m1_wdata = 0; bif0.bus_rdata = 0;
    bif15.m0_req = 0; bif15.m1_req = 0; bif15.m0_we = 0; bif15.m1_we = 0;
    bif15.m0_addr = 0; bif15.m1_addr = 0; bif15.m0_wdata = 0; bif15.m1_wdata = 0; bif15.bus_rdata = 0;

    //              r0 r1 we0 we1 a0     a1     wd0      wd1      brd            a0n a1n rd0           rd1           e0   e1   wef     wec   sel   addr   wdc      lsel
    vecs[0] = mk(1, 0, 1, 0, 8'h80, 8'h00, 32'h5A, 32'h0,  32'hDEAD,      4, 0, 32'h0,        32'h0,        0,   0,   2,      1,    3'd4, 5'd0,  32'h5A,  3'd4);
    vecs[1] = mk(0, 1, 0, 0, 8'h00, 8'hC3, 32'h0,  32'h0,  32'h1234,      0, 4, 32'h0,        32'h1234,     0,   0,   0,      0,    3'd6, 5'd3,  32'h0,   3'd6);
    vecs[2] = mk(1, 0, 0, 0, 8'h45, 8'h00, 32'h11, 32'h0,  32'hCAFE0001,  4, 0, 32'hCAFE0001, 32'h1234,     0,   0,   0,      0,    3'd2, 5'd5,  32'h11,  3'd2);
    vecs[3] = mk(1, 1, 0, 1, 8'h61, 8'hA2, 32'h0,  32'h77, 32'hBEEF,      9, 4, 32'hBEEF,     32'h1234,     0,   0,   2,      1,    3'd5, 5'd2,  32'h77,  3'd3);
    vecs[4] = mk(1, 1, 1, 0, 8'h1F, 8'h84, 32'h1,  32'h0,  32'h55AA,      9, 4, 32'hBEEF,     32'h55AA,     0,   0,   7,      1,    3'd4, 5'd4,  32'h0,   3'd0);
    vecs[5] = mk(0, 1, 0, 0, 8'h00, 8'hFF, 32'h0,  32'h0,  32'h0F0F,      0, UNM ? 2 : 4,
                 32'hBEEF, UNM ? 32'h0 : 32'h0F0F, 0, UNM, 0, 0, 3'd7, 5'd31, 32'h0, 3'd7);
    vecs[6] = mk(1, 0, 1, 0, 8'h20, 8'h00, 32'h99, 32'h0,  32'h1111,      UNM ? 2 : 4, 0,
                 UNM ? 32'h0 : 32'hBEEF, UNM ? 32'h0 : 32'h0F0F, UNM, 0, UNM ? 0 : 2, UNM ? 0 : 1,
                 3'd1, 5'd0, 32'h99, 3'd1);

    #3;
    chk_reset_vals("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_reset");

    for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

    // Abort an m1 write in ACCESS after its strobe has been issued.
    @(negedge clk);
    bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 8'hA0; bif.m1_wdata = 32'h33;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort we_before_reset", 32'(bif.WE_procesador), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    bif.m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bif.m1_ack || bif.m0_ack || bif.WE_procesador) ack_seen++;
    end
    chk("abort no_ack_no_we", 32'(ack_seen), 32'd0);
    $display("txn abort: m1 write reset in ACCESS, late activity=%0d", ack_seen);

    apply_vec(7, mk(1, 1, 0, 0, 8'h40, 8'h60, 32'h0, 32'h0, 32'h42, 4, 9, 32'h42, 32'h42,
                    0, 0, 0, 0, 3'd2, 5'd0, 32'h0, 3'd3));

    // WAIT_CYC 0 and 15: bus_rdata carries the marker only in the final ACCESS cycle.
    @(negedge clk);
    bif0.m0_req = 1'b1;  bif0.m0_addr = 8'h41;
    bif15.m0_req = 1'b1; bif15.m0_addr = 8'h41;
    n = 0; got0 = 0; got15 = 0;
    bif0.bus_rdata = 32'h1000; bif15.bus_rdata = 32'h2000;
    while ((got0 == 0 || got15 == 0) && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bif0.m0_ack && got0 == 0) begin
        got0 = n;
        chk("w0 m0_rdata", bif0.m0_rdata, 32'hA0A0);
        bif0.m0_req = 1'b0;
      end
      if (bif15.m0_ack && got15 == 0) begin
        got15 = n;
        chk("w15 m0_rdata", bif15.m0_rdata, 32'hF15F);
        bif15.m0_req = 1'b0;
      end
      bif0.bus_rdata  = (n == 2)  ? 32'hA0A0 : 32'h1000 + 32'(n);
      bif15.bus_rdata = (n == 17) ? 32'hF15F : 32'h2000 + 32'(n);
    end
    chk("w0 ack_cycle", 32'(got0), 32'd3);
    chk("w15 ack_cycle", 32'(got15), 32'd18);
    $display("txn sweep: WAIT_CYC=0 ack@%0d rdata=%h, WAIT_CYC=15 ack@%0d rdata=%h",
             got0, bif0.m0_rdata, got15, bif15.m0_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and access sequencer for the microcontroller's peripheral bus. It sits between the processor port (master 0) and the ADC sample mover (master 1) on one side, and the peripheral write-enable demultiplexer and read-back mux on the other. It grants one master at a time with round-robin fairness and drives the 3-bit peripheral select, register offset, write data and a single-cycle write strobe. It then waits a fixed number of wait states, captures read data and returns a one-cycle acknowledge to the granted master.

## Interface
Parameters:
- DATA_W, 32, data width of both masters and the bus.
- WAIT_CYC, 1, extra access cycles before read data is sampled; legal range 0..15.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  transaction request; held high until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  in  8  [7:5] = peripheral select, [4:0] = register offset.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  DATA_W  read data; valid while ack is high, held until the next ack to that master.
- m0_err, m1_err  out  1  error flag; qualified by ack.
- SEL  out  3  peripheral select to the demux and read mux.
- WE_procesador  out  1  write strobe to the demux.
- bus_addr  out  5  register offset.
- bus_wdata  out  DATA_W  write data.
- bus_rdata  in  DATA_W  read data returned by the selected peripheral.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE
  - With no request pending, the FSM stays in IDLE.
  - With exactly one request, that master is granted.
  - With both requesting, the master not granted last wins.
  - `last_grant` resets to 1, so m0 wins the first contention after reset.
  - On a grant, the master's addr, we and wdata are registered into SEL, bus_addr, bus_wdata and a we latch, and the FSM goes to SETUP.
- SETUP
  - Lasts one cycle.
  - Bus outputs are stable and WE_procesador = 0.
  - Next state is ACCESS, with the wait counter loaded to WAIT_CYC.
- ACCESS
  - Lasts WAIT_CYC+1 cycles.
  - WE_procesador = latched we during the first ACCESS cycle only, otherwise 0.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, bus_rdata is captured into the granted master's rdata register (reads only; writes leave rdata unchanged) and the FSM goes to DONE.
- DONE
  - Lasts one cycle.
  - The granted master's ack = 1 and err = 0.
  - `last_grant` is updated to the granted master.
  - Next state is IDLE.
- SEL, bus_addr and bus_wdata hold their last values in IDLE; they are not zeroed.
- Reset mid-transaction:
  - Everything returns to its reset value immediately.
  - No ack is ever produced for the aborted access.
  - A write strobe already issued is not repeated.
- A req that drops before its ack is a protocol violation. The transaction still completes, and the ack is still pulsed to that master.

## Timing
- Reset values:
  - State = IDLE, last_grant = 1.
  - SEL = 0, WE_procesador = 0, bus_addr = 0, bus_wdata = 0.
  - All ack, err and rdata outputs = 0; busy = 0.
- Request sampled in IDLE at cycle 0 gives:
  - SETUP at cycle 1.
  - WE pulse at cycle 2.
  - rdata sampled at cycle 2+WAIT_CYC.
  - ack at cycle 3+WAIT_CYC.
- WE_procesador is exactly one cycle wide per write and is never high in SETUP, DONE or IDLE.
- Back-to-back transactions:
  - DONE is always followed by IDLE, so the minimum spacing is 4+WAIT_CYC cycles per transaction.
  - A requester seeing ack at edge k must have req low in cycle k+1, or a new transaction starts.
- Both ack outputs are never high in the same cycle.

## Configuration
- UNMAPPED_ERR_EN defined:
  - SEL values 1 and 7 are unmapped.
  - On a grant to an unmapped address, SETUP goes directly to DONE; ACCESS is skipped and no WE pulse is issued.
  - In DONE, ack = 1, err = 1, and the master's rdata is forced to 0.
  - Ack arrives at cycle 2 after the request is sampled.
- UNMAPPED_ERR_EN undefined:
  - All SEL values run the full sequence.
  - err outputs are tied to 0.

## Test plan
- Reset, then m0 write addr 0x80 (SEL 4, LEDs), wdata 0x5A, WAIT_CYC=1 -> SEL=4, bus_addr=0, WE_procesador high only in cycle 2; m0_ack at cycle 4; m1_ack stays 0.
- m1 read addr 0xC3 (SEL 6, timer, offset 3), bus_rdata=0x1234 -> m1_rdata=0x1234 with m1_ack at cycle 4; WE_procesador stays 0.
- m0_req and m1_req both rise in the same cycle after reset, each held until acked -> m0 served first, then m1; next simultaneous pair -> m1 first? No, alternation continues: m0 then m1 again only if m1 was granted last.
- rst_n pulsed low during ACCESS of an m1 write -> all outputs return to reset values asynchronously; no m1_ack; the next grant behaves as after reset.
- With UNMAPPED_ERR_EN: m0 write addr 0x20 (SEL 1) -> no WE pulse, m0_ack and m0_err high at cycle 2, m0_rdata=0. Without it -> full sequence, WE pulse at cycle 2, err=0.
- WAIT_CYC=0 and WAIT_CYC=15 sweeps on a read -> ack at cycles 3 and 18 respectively; rdata sampled in the last ACCESS cycle.
